// File: rtl/stream_block_collector.sv
`default_nettype none
// ============================================================================
// Module   : stream_block_collector
// Purpose  : Collects a valid-qualified serial sample stream into parallel
//            N-sample blocks using a ping-pong pair of block registers, with
//            a ready/valid block output and a sticky overflow flag for
//            samples that arrive while both banks are full.
// Revision : 1.0 - initial release
// ============================================================================
module stream_block_collector #(
    parameter int WIDTH = 16,
    parameter int N     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*WIDTH-1:0]      out_data,
    output logic                    overflow
);

    localparam int                CNT_W      = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]  c_LAST_IDX = CNT_W'(N - 1);

    // Two block banks; element 0 of a bank holds the first sample of its block.
    logic [WIDTH-1:0] bank_q [2][N];

    logic [1:0]       full_q,    full_d;
    logic             wb_q,      wb_d;
    logic             rb_q,      rb_d;
    logic [CNT_W-1:0] wr_cnt_q,  wr_cnt_d;
    logic             overflow_q, overflow_d;

    logic             wr_en_w;
    logic             drop_w;
    logic             rd_en_w;

    // A sample is stored only into a bank that is not holding a finished block.
    assign wr_en_w = in_valid &&  !full_q[wb_q];
    assign drop_w  = in_valid &&   full_q[wb_q];
    assign rd_en_w = full_q[rb_q] && out_ready;

    // Next-state for bank occupancy, pointers, write index and overflow.
    always_comb begin
        full_d     = full_q;
        wb_d       = wb_q;
        rb_d       = rb_q;
        wr_cnt_d   = wr_cnt_q;
        overflow_d = overflow_q;

        // Consume frees the read bank; a write can never target this same bank
        // in the same cycle because writes require the target bank to be empty.
        if (rd_en_w) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
        end

        if (wr_en_w) begin
            if (wr_cnt_q == c_LAST_IDX) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
                wr_cnt_d     = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end

        if (drop_w) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wr_cnt_q   <= wr_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Bank storage: zeroed on reset, one element written per accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
        end else if (wr_en_w) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    if ((wb_q == b[0]) && (wr_cnt_q == CNT_W'(i))) begin
                        bank_q[b][i] <= in_data;
                    end
                end
            end
        end
    end

    // Output block comes straight from the read bank registers.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_out
            assign out_data[gi*WIDTH +: WIDTH] = rb_q ? bank_q[1][gi] : bank_q[0][gi];
        end
    endgenerate

    assign out_valid = full_q[rb_q];
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: doc/stream_block_collector.md
# stream_block_collector

Converts the valid-qualified serial sample stream produced by the DCT datapath's delay/alignment stages back into parallel N-sample blocks for block-level consumers such as the transpose stage and output packing. A ping-pong pair of block registers lets the upstream stream keep running while a finished block waits on a ready/valid output handshake. The upstream has no backpressure, so samples arriving while both banks are full are dropped and a sticky overflow flag is set.

## Interface
- WIDTH, 16, bits per signed sample
- N, 8, samples per block; must be at least 2
- clk  in  1  rising-edge clock
- rst  in  1  reset: one clock, synchronous, active-high
- in_valid  in  1  sample strobe; no ready is returned upstream
- in_data  in  signed WIDTH  sample, sampled only when in_valid=1
- out_valid  out  1  a complete block is presented
- out_ready  in  1  consumer accepts the block when out_valid=1 and out_ready=1
- out_data  out  N*WIDTH  block; element i is at bits [i*WIDTH +: WIDTH], and element 0 is the first sample received
- overflow  out  1  sticky; set on any dropped sample, cleared only by rst

## Operation
- State:
  - banks bank[0], bank[1], each N×WIDTH
  - full[1:0]
  - write bank wb
  - write index wr_cnt (0..N-1)
  - read bank rb
  - overflow
- Write side, on a clock edge with in_valid=1:
  - Evaluation uses the state before the edge.
  - If full[wb]=0: bank[wb][wr_cnt] <= in_data.
  - If full[wb]=0 and wr_cnt==N-1: full[wb] <= 1, wb toggles, wr_cnt <= 0.
  - If full[wb]=0 and wr_cnt<N-1: wr_cnt increments.
  - If full[wb]=1: the sample is dropped, overflow <= 1, and wr_cnt and wb are unchanged.
- Read side:
  - out_valid = full[rb].
  - out_data = bank[rb], driven directly from the bank registers.
  - On out_valid && out_ready: full[rb] <= 0 and rb toggles.
  - When out_valid=0, out_ready is ignored.
- Simultaneous events:
  - Consume and frame-complete in the same cycle: both take effect. If they target different banks, out_valid stays 1 and the next block is presented on the following cycle with no bubble.
  - Consume and a write to the same full bank (both banks full, wb==rb): the write is dropped and overflow is set. The freed bank is writable from the next cycle.
- Data is stored bit-exact, with no arithmetic or sign manipulation. out_data is unchanged while out_valid=1 and no handshake occurs.
- Reset clears everything:
  - banks are zeroed
  - full=0, wb=0, rb=0, wr_cnt=0
  - out_valid=0, out_data=0, overflow=0
  - Partially collected samples are discarded.

## Timing
- Latency: the Nth sample of a block is captured at edge k; out_valid=1 from edge k (visible in cycle k+1), provided the read side was idle.
- Handshake: a block is transferred on any edge where out_valid=1 and out_ready=1. out_valid for the same bank falls after that edge.
- Throughput: one sample per clock, indefinitely, whenever out_ready=1 in each cycle where out_valid=1. Block output then occupies one cycle per N input cycles.
- Backpressure tolerance: with out_ready held low, 2N samples are absorbed. Sample 2N+1 is dropped.
- Reset asserted mid-frame takes effect at the next edge and overrides any concurrent in_valid or handshake.
- overflow is registered: it rises in the cycle after the dropped sample's edge.

## Test plan
- **Reset:** hold rst for 2 cycles with in_valid=1 and out_ready=1 → out_valid=0, out_data=0, overflow=0 throughout and in the first cycle after release.
- **Single block:** out_ready=0; feed 1..8 back-to-back.
  - Required: out_valid=1 the cycle after sample 8, element i = i+1, held stable for 5 cycles.
  - Then assert out_ready for one cycle → out_valid=0 on the next cycle.
- **Continuous streaming:** out_ready=1; feed 24 consecutive samples 0..23.
  - Required: three blocks {0..7}, {8..15}, {16..23}, each out_valid pulse exactly 1 cycle, pulses 8 cycles apart, overflow=0.
- **Overflow:** out_ready=0; feed 17 samples 1..17.
  - Required: overflow=1 after sample 17.
  - Then raise out_ready → blocks {1..8} then {9..16} on consecutive cycles.
  - Then feed 100 → it lands in element 0 of the next block; overflow remains 1.
- **Gapped and extreme values:** alternate in_valid 1/0 with samples -32768, 32767, -1, 0, 1, 2, 3, 4 → one block with exactly those element values in order.
- **Reset mid-frame:** feed 5 samples, pulse rst, then feed 10..17 → the first output block is {10..17}; no block containing pre-reset samples ever appears.
